// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Brief    : N-digit seven-segment time multiplexer with dwell, blanking,
//             per-digit skip, anode polarity and frame-start strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int DIGIT_W          = 4,
    parameter int DWELL_CYCLES     = 48000,
    parameter int BLANK_CYCLES     = 480,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]                       digits_in,
    input  logic [NUM_DIGITS-1:0]                               digit_en,
    output logic [NUM_DIGITS-1:0]                               anodes,
    output logic [DIGIT_W-1:0]                                  digit_out,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
    output logic                                                frame_start
);

    localparam int c_SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_MAX_A  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_MAX_C  = (c_MAX_A < 2) ? 2 : c_MAX_A;
    localparam int c_CNT_W  = $clog2(c_MAX_C);

    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        c_CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic c_ANODE_ON = (ANODE_ACTIVE_LOW == 0);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    logic [0:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_SEL_W-1:0]    r_idx;
    logic                  r_first;
    logic [NUM_DIGITS-1:0] r_anodes;
    logic [DIGIT_W-1:0]    r_digit_out;
    logic [c_SEL_W-1:0]    r_digit_sel;
    logic                  r_frame_start;

    logic [0:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_SEL_W-1:0]    w_idx_nxt;
    logic                  w_load;
    logic                  w_found;
    logic [c_SEL_W-1:0]    w_sel;
    logic [NUM_DIGITS-1:0] w_anodes_nxt;
    logic [DIGIT_W-1:0]    w_digit_out_nxt;
    logic [c_SEL_W-1:0]    w_digit_sel_nxt;
    logic                  w_frame_start_nxt;

    // Circular search for the next enabled digit; the first pick after
    // reset includes index 0 itself, later picks start just past r_idx.
    always_comb begin
        int w_start;
        int w_cand;
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = 0;
        w_start = r_first ? 0 : int'(r_idx) + 1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_cand = (w_start + k) % NUM_DIGITS;
            if (!w_found && digit_en[w_cand]) begin
                w_found = 1'b1;
                w_sel   = c_SEL_W'(w_cand);
            end
        end
    end

    // State register, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_first       <= 1'b1;
            r_anodes      <= c_ANODE_OFF;
            r_digit_out   <= '0;
            r_digit_sel   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_first       <= r_first & ~w_load;
            r_anodes      <= w_anodes_nxt;
            r_digit_out   <= w_digit_out_nxt;
            r_digit_sel   <= w_digit_sel_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            c_ST_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_found) begin
                        w_state_nxt = c_ST_SHOW;
                        w_idx_nxt   = w_sel;
                        w_load      = 1'b1;
                    end
                end
            end
            default: begin
                if (r_cnt == c_DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if ((BLANK_CYCLES == 0) && w_found) begin
                        w_idx_nxt = w_sel;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_BLANK;
                    end
                end
            end
        endcase
    end

    // Output logic: code and index latch only on SHOW entry, so digits_in
    // changes during a dwell never reach the segment decoder mid-digit.
    always_comb begin
        w_anodes_nxt      = c_ANODE_OFF;
        w_digit_out_nxt   = r_digit_out;
        w_digit_sel_nxt   = r_digit_sel;
        w_frame_start_nxt = 1'b0;
        if (w_load) begin
            w_digit_out_nxt   = digits_in[int'(w_sel)*DIGIT_W +: DIGIT_W];
            w_digit_sel_nxt   = w_sel;
            w_frame_start_nxt = r_first || (w_sel <= r_idx);
        end
        if ((w_state_nxt == c_ST_SHOW) && digit_en[w_idx_nxt]) begin
            w_anodes_nxt[w_idx_nxt] = c_ANODE_ON;
        end
    end

    assign anodes      = r_anodes;
    assign digit_out   = r_digit_out;
    assign digit_sel   = r_digit_sel;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Brief    : Self-checking bench for seg_scan_mux (scoreboard of expected
//             per-cycle outputs plus a property monitor on a no-blank copy).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  digit_en;

    logic [3:0]  an_a, dout_a, an_b, dout_b;
    logic [1:0]  sel_a, sel_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en),
        .anodes(an_a), .digit_out(dout_a), .digit_sel(sel_a), .frame_start(fs_a)
    );

    seg_scan_mux #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DWELL_CYCLES(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(0)
    ) dut_nb (
        .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en),
        .anodes(an_b), .digit_out(dout_b), .digit_sel(sel_b), .frame_start(fs_b)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] dout;
        logic [1:0] sel;
        logic       fs;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] en;
        int         n;
        int         ord [4];
    } row_t;

    exp_t sb_q[$];
    row_t rows[4];
    int   tests = 0;
    int   fails = 0;
    int   tick  = 0;
    int   base  = 0;
    logic b_on  = 1'b0;
    int   b_run = 0;
    logic [3:0] b_prev = 4'b0;

    always @(posedge clk) tick <= tick + 1;

    // Scoreboard checker for the blanking DUT and property monitor for the
    // no-blank, active-high DUT.
    always @(negedge clk) begin
        int   c;
        exp_t e;
        c = tick - base;
        while (sb_q.size() > 0 && sb_q[0].cyc <= c) begin
            e = sb_q.pop_front();
            tests++;
            if (e.cyc != c) begin
                fails++;
                $display("FAIL scan_late: entry for cycle %0d reached at cycle %0d", e.cyc, c);
            end else if (an_a !== e.an || dout_a !== e.dout || sel_a !== e.sel || fs_a !== e.fs) begin
                fails++;
                $display("FAIL scan c=%0d: anodes=%b digit_out=%h sel=%0d fs=%b, expected anodes=%b digit_out=%h sel=%0d fs=%b",
                         c, an_a, dout_a, sel_a, fs_a, e.an, e.dout, e.sel, e.fs);
            end
        end
        if (b_on) begin
            tests++;
            if (c == 0) begin
                if (an_b !== 4'b0000) begin
                    fails++;
                    $display("FAIL noblank_reset: anodes=%b expected 0000", an_b);
                end
                b_run  = 0;
                b_prev = 4'b0;
            end else begin
                if (!$onehot(an_b) || an_b !== (4'b0001 << dout_b)) begin
                    fails++;
                    $display("FAIL noblank_onehot c=%0d: anodes=%b digit_out=%h", c, an_b, dout_b);
                end
                if (an_b === b_prev) begin
                    b_run++;
                end else begin
                    if (b_prev != 4'b0 && (b_run != 8 || an_b !== {b_prev[2:0], b_prev[3]})) begin
                        fails++;
                        $display("FAIL noblank_dwell c=%0d: run=%0d prev=%b next=%b, expected run=8 next=%b",
                                 c, b_run, b_prev, an_b, {b_prev[2:0], b_prev[3]});
                    end
                    b_run  = 1;
                    b_prev = an_b;
                end
            end
        end
    end

    function automatic row_t mk_row(string name, logic [3:0] en, int n, int o0, int o1, int o2, int o3);
        row_t r;
        r.name = name; r.en = en; r.n = n;
        r.ord[0] = o0; r.ord[1] = o1; r.ord[2] = o2; r.ord[3] = o3;
        return r;
    endfunction

    // Value latched for digit d at the SHOW entry of slot k (entry edge at k*10+1)
    function automatic logic [3:0] dval(int d, int k, int chg, logic [3:0] d0new);
        if (d == 0 && chg <= k*10 + 1) return d0new;
        return 4'(d);
    endfunction

    // Expected outputs at cycle c after reset: 10-cycle slots of 2 blank + 8 lit
    function automatic exp_t exp_scan(row_t r, int c, int chg, logic [3:0] d0new);
        exp_t e;
        int k, s, d, pd;
        k = c / 10; s = c % 10; d = r.ord[k % r.n];
        e.cyc = c;
        if (s >= 2) begin
            e.an   = ~(4'b0001 << d);
            e.dout = dval(d, k, chg, d0new);
            e.sel  = 2'(d);
            e.fs   = (s == 2) && (k % r.n == 0);
        end else begin
            e.an = 4'hF;
            e.fs = 1'b0;
            if (k == 0) begin
                e.dout = 4'h0; e.sel = 2'd0;
            end else begin
                pd     = r.ord[(k-1) % r.n];
                e.dout = dval(pd, k-1, chg, d0new);
                e.sel  = 2'(pd);
            end
        end
        return e;
    endfunction

    function automatic exp_t mk_exp(int c, logic [3:0] an, logic [3:0] dout, logic [1:0] sel, logic fs);
        exp_t e;
        e.cyc = c; e.an = an; e.dout = dout; e.sel = sel; e.fs = fs;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = tick;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        reset     = 1'b1;
        digit_en  = 4'b0;
        digits_in = 16'h3210;
        rows[0] = mk_row("basic",  4'b1111, 4, 0, 1, 2, 3);
        rows[1] = mk_row("skip",   4'b1010, 2, 1, 3, 0, 0);
        rows[2] = mk_row("single", 4'b0100, 1, 2, 0, 0, 0);
        rows[3] = mk_row("ends",   4'b1001, 2, 0, 3, 0, 0);
        step(3);

        for (int i = 0; i < 4; i++) begin
            digit_en  = rows[i].en;
            digits_in = 16'h3210;
            do_reset();
            b_on = (i == 0);
            for (int c = 0; c < rows[i].n * 20; c++)
                sb_q.push_back(exp_scan(rows[i], c, 1 << 30, 4'h0));
            step(rows[i].n * 20);
            b_on = 1'b0;
        end

        // No enables for 100 cycles, then only digit 2
        digit_en = 4'b0000;
        do_reset();
        for (int c = 0; c < 100; c++) sb_q.push_back(mk_exp(c, 4'hF, 4'h0, 2'd0, 1'b0));
        step(100);
        digit_en = 4'b0100;
        sb_q.push_back(mk_exp(100, 4'hF, 4'h0, 2'd0, 1'b0));
        sb_q.push_back(mk_exp(101, 4'hF, 4'h0, 2'd0, 1'b0));
        for (int c = 102; c < 132; c++) begin
            r = (c - 100) % 10;
            if (r >= 2) sb_q.push_back(mk_exp(c, 4'b1011, 4'h2, 2'd2, r == 2));
            else        sb_q.push_back(mk_exp(c, 4'hF, 4'h2, 2'd2, 1'b0));
        end
        step(32);

        // Digit 0 code changes mid-dwell: visible only on the next visit
        digit_en  = 4'b1111;
        digits_in = 16'h3210;
        do_reset();
        for (int c = 0; c < 5; c++) sb_q.push_back(exp_scan(rows[0], c, 1 << 30, 4'h0));
        step(5);
        digits_in[3:0] = 4'h9;
        for (int c = 5; c < 50; c++) sb_q.push_back(exp_scan(rows[0], c, 5, 4'h9));
        step(45);
        digits_in = 16'h3210;

        // Enable of digit 1 dropped mid-dwell, then reset mid-SHOW of digit 2
        do_reset();
        for (int c = 0; c < 15; c++) sb_q.push_back(exp_scan(rows[0], c, 1 << 30, 4'h0));
        step(14);
        digit_en = 4'b1101;
        for (int c = 15; c < 22; c++) sb_q.push_back(mk_exp(c, 4'hF, 4'h1, 2'd1, 1'b0));
        for (int c = 22; c < 26; c++) sb_q.push_back(mk_exp(c, 4'b1011, 4'h2, 2'd2, 1'b0));
        step(11);
        digit_en = 4'b1111;
        do_reset();
        for (int c = 0; c < 22; c++) sb_q.push_back(exp_scan(rows[0], c, 1 << 30, 4'h0));
        step(22);

        step(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised N-digit time multiplexer for common-anode/cathode seven-segment banks. It scans NUM_DIGITS digit codes onto one shared digit bus and a one-hot anode vector, so a single downstream segment decoder drives the whole bank. Versus a fixed two-digit toggle it adds:
- configurable dwell time
- a break-before-make blanking interval
- per-digit enables with skip
- anode polarity selection
- a frame-start strobe

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..16)
DIGIT_W, 4, width of each digit code
DWELL_CYCLES, 48000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 480, clk cycles all anodes are off between digits (0 = no blanking)
ANODE_ACTIVE_LOW, 1, 1: lit anode driven 0; 0: lit anode driven 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
digits_in  input  NUM_DIGITS*DIGIT_W  digit codes; digit k = bits [k*DIGIT_W +: DIGIT_W]
digit_en  input  NUM_DIGITS  per-digit enable; 0 = skip digit
anodes  output  NUM_DIGITS  anode drives, polarity per ANODE_ACTIVE_LOW
digit_out  output  DIGIT_W  code of the currently lit digit, to the segment decoder
digit_sel  output  max(1,$clog2(NUM_DIGITS))  index of the current or last lit digit
frame_start  output  1  one-cycle strobe at the start of each scan frame

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Registered outputs: all outputs are registered.
- Reset values:
  - anodes = all off (all 1s if ANODE_ACTIVE_LOW, else all 0s)
  - digit_out = 0, digit_sel = 0, frame_start = 0
  - state = BLANK, dwell counter = 0, idx = 0
- Reset mid-operation: asserting reset returns to these values on the next edge, with no partial dwell completed.
- FSM states:
  - BLANK: all anodes off. Counter runs 0..BLANK_CYCLES-1. On the terminal count, if any digit_en bit is set, load the next index and go to SHOW. If no bit is set, stay in BLANK, restart the counter and keep idx.
  - SHOW: anode[idx] lit, digit_out = latched code of digit idx, counter runs 0..DWELL_CYCLES-1. On the terminal count, go to BLANK. If BLANK_CYCLES = 0, go directly to SHOW of the next digit with no off cycle.
- Counter: clears on every state entry.
- Next-index rule:
  - Circular search from idx+1 (wrapping NUM_DIGITS-1 -> 0) for the first set digit_en bit, sampled on the transition cycle.
  - If only the current digit is enabled, it is reselected.
  - The very first selection after reset searches from index 0 inclusive.
- Timing: with reset released, the first cycle out of reset is cycle 0, in BLANK. The first enabled digit's anode is lit from cycle BLANK_CYCLES for exactly DWELL_CYCLES cycles. Period per digit = DWELL_CYCLES + BLANK_CYCLES.
- Data latching: digit_out and digit_sel load on entry to SHOW and hold through SHOW and the following BLANK. Changes to digits_in during SHOW take effect at the next SHOW entry, so there is no mid-dwell glitch.
- Enable dropped during SHOW: if digit_en[idx] drops, anode[idx] goes off on the next cycle. The counter continues and the FSM proceeds normally.
- Anode exclusivity: at most one anode is lit in any cycle. No two anodes are lit in consecutive cycles unless BLANK_CYCLES = 0.
- frame_start:
  - Asserted for exactly the first cycle of SHOW when the selected idx is <= the previously shown idx (wrap), or on the first SHOW after reset.
  - With a single enabled digit it pulses every SHOW entry.
- Arithmetic: counter width = $clog2(max(DWELL_CYCLES, BLANK_CYCLES, 2)). Terminal compares are against the parameter minus 1; there are no overflow paths.

Test Plan:
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1, digits_in = {4'h3, 4'h2, 4'h1, 4'h0}.
- Basic scan: digit_en=4'b1111, release reset.
  - anodes=4'b1111 for cycles 0-1, then 4'b1110 for cycles 2-9 with digit_out=0, digit_sel=0 and frame_start high in cycle 2 only.
  - Then 2 cycles of 4'b1111, then 4'b1101 with digit_out=1.
  - The full sequence repeats every 40 cycles.
- Skip: digit_en=4'b1010.
  - Only anodes 1 and 3 are lit, in alternation, with digit_out 1 and 3.
  - Period 20 cycles; frame_start pulses on each entry to digit 1.
- No enables: digit_en=0 for 100 cycles, then set 4'b0100.
  - anodes stay 4'b1111 throughout the 100 cycles.
  - After enabling, digit 2 lights within 2 cycles of the next BLANK terminal count, and frame_start pulses every 10 cycles.
- Glitch-free data: change digits_in digit 0 to 4'h9 mid-dwell of digit 0.
  - digit_out stays 0 until that dwell ends.
  - digit_out shows 9 on the next visit to digit 0.
- Enable drop and reset:
  - Clear digit_en[1] mid-dwell of digit 1: anodes return to 4'b1111 the next cycle, and the following SHOW is digit 2.
  - Assert reset for 1 cycle mid-SHOW: all outputs return to reset values on the next edge, and the sequence restarts from cycle 0.
- Parameter sweep: repeat the basic scan with BLANK_CYCLES=0 and ANODE_ACTIVE_LOW=0.
  - Anodes are active-high one-hot with no off cycles between digits.
  - Each digit is lit for exactly 8 cycles.
